// File: rtl/binary_conv_mac.sv
// Binary (XOR-sign) convolution MAC: serial-loaded TAPS-wide kernel, one window per beat,
// saturating group accumulation and a registered result strobe with write address/index.
module binary_conv_mac #(
  parameter int TAPS   = 9,
  parameter int ACC_W  = 8,
  parameter int ADDR_W = 12,
  parameter int IDX_W  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     go,
  input  logic                     load_weight,
  input  logic                     weight_in,
  input  logic                     data_valid,
  input  logic [TAPS-1:0]          data_in,
  input  logic                     last_in,
  input  logic [ADDR_W-1:0]        write_addr_in,
  input  logic [IDX_W-1:0]         idx_in,
  output logic                     weights_ready,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  sum_out,
  output logic                     negative_flag,
  output logic                     sat_flag,
  output logic [ADDR_W-1:0]        write_addr_out,
  output logic [IDX_W-1:0]         idx_out
);

  typedef enum logic [1:0] {EMPTY, LOADING, READY, ACCUM} state_t;

  localparam int CNT_W = $clog2(TAPS + 1);
  localparam int MAX_I = 2**(ACC_W-1) - 1;
  localparam int MIN_I = -(2**(ACC_W-1));
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(MAX_I);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(MIN_I);

  // Matching bits contribute +1, differing bits -1.
  function automatic logic signed [ACC_W-1:0] bin_dot(input logic [TAPS-1:0] k,
                                                      input logic [TAPS-1:0] d);
    logic signed [ACC_W-1:0] s;
    s = ACC_W'(TAPS);
    for (int i = 0; i < TAPS; i++)
      if (k[i] ^ d[i]) s = s - ACC_W'(2);
    return s;
  endfunction

  function automatic logic sat_hit(input logic signed [ACC_W:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_clip(input logic signed [ACC_W:0] v);
    if (v > SAT_MAX) return ACC_W'(MAX_I);
    if (v < SAT_MIN) return ACC_W'(MIN_I);
    return v[ACC_W-1:0];
  endfunction

  state_t                   state;
  logic [TAPS-1:0]          kernel;
  logic [CNT_W-1:0]         wcount;
  logic                     accept;

  logic                     vld_p0, last_p0;
  logic [TAPS-1:0]          data_p0;
  logic [ADDR_W-1:0]        addr_p0;
  logic [IDX_W-1:0]         idx_p0;

  logic                     vld_p1, last_p1;
  logic signed [ACC_W-1:0]  partial_p1;
  logic [ADDR_W-1:0]        addr_p1;
  logic [IDX_W-1:0]         idx_p1;

  logic signed [ACC_W-1:0]  acc;
  logic                     sat_grp;
  logic signed [ACC_W:0]    sum_ext;
  logic signed [ACC_W-1:0]  sum_clip;
  logic                     sum_hit;

  assign accept = go & data_valid & weights_ready & ~load_weight;

  always_comb begin
    sum_ext = (ACC_W+1)'(partial_p1);
    if (state != READY) sum_ext = sum_ext + (ACC_W+1)'(acc);
    sum_clip = sat_clip(sum_ext);
    sum_hit  = sat_hit(sum_ext);
  end

  // Stage p0: capture accepted beat; stage p1: binary dot product.
  always_ff @(posedge clock) begin
    if (accept) begin
      data_p0 <= data_in;
      last_p0 <= last_in;
      addr_p0 <= write_addr_in;
      idx_p0  <= idx_in;
    end
    if (vld_p0) begin
      partial_p1 <= bin_dot(kernel, data_p0);
      last_p1    <= last_p0;
      addr_p1    <= addr_p0;
      idx_p1     <= idx_p0;
    end
  end

  // Stage p2: kernel load, group accumulation and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= EMPTY;
      kernel         <= '0;
      wcount         <= '0;
      weights_ready  <= 1'b0;
      vld_p0         <= 1'b0;
      vld_p1         <= 1'b0;
      acc            <= '0;
      sat_grp        <= 1'b0;
      out_valid      <= 1'b0;
      sum_out        <= '0;
      negative_flag  <= 1'b0;
      sat_flag       <= 1'b0;
      write_addr_out <= '0;
      idx_out        <= '0;
    end else begin
      out_valid <= 1'b0;
      vld_p0    <= accept;
      vld_p1    <= vld_p0 & ~load_weight;
      if (load_weight) begin
        // A load flushes in-flight beats and aborts any open group.
        kernel  <= {kernel[TAPS-2:0], weight_in};
        acc     <= '0;
        sat_grp <= 1'b0;
        if (state == READY || state == ACCUM) begin
          wcount        <= CNT_W'(1);
          weights_ready <= 1'b0;
          state         <= LOADING;
        end else if (wcount == CNT_W'(TAPS - 1)) begin
          wcount        <= CNT_W'(TAPS);
          weights_ready <= 1'b1;
          state         <= READY;
        end else begin
          wcount <= wcount + CNT_W'(1);
          state  <= LOADING;
        end
      end else if (vld_p1) begin
        if (last_p1) begin
          out_valid      <= 1'b1;
          sum_out        <= sum_clip;
          negative_flag  <= sum_clip[ACC_W-1];
          sat_flag       <= sat_grp | sum_hit;
          write_addr_out <= addr_p1;
          idx_out        <= idx_p1;
          acc            <= '0;
          sat_grp        <= 1'b0;
          state          <= READY;
        end else begin
          acc     <= sum_clip;
          sat_grp <= sat_grp | sum_hit;
          state   <= ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_binary_conv_mac.sv
// Directed bench for binary_conv_mac: load, single beat, groups, saturation, abort, async reset.
module tb_binary_conv_mac;

  logic              clock = 1'b0;
  logic              reset;
  logic              go, load_weight, weight_in, data_valid, last_in;
  logic [8:0]        data_in;
  logic [11:0]       write_addr_in;
  logic [3:0]        idx_in;
  logic              weights_ready, out_valid, negative_flag, sat_flag;
  logic signed [7:0] sum_out;
  logic [11:0]       write_addr_out;
  logic [3:0]        idx_out;

  int n_asrt = 0;
  int n_fail = 0;
  logic [8:0] kern_new;

  binary_conv_mac #(.TAPS(9), .ACC_W(8), .ADDR_W(12), .IDX_W(4)) dut (
    .clock(clock), .reset(reset), .go(go), .load_weight(load_weight),
    .weight_in(weight_in), .data_valid(data_valid), .data_in(data_in),
    .last_in(last_in), .write_addr_in(write_addr_in), .idx_in(idx_in),
    .weights_ready(weights_ready), .out_valid(out_valid), .sum_out(sum_out),
    .negative_flag(negative_flag), .sat_flag(sat_flag),
    .write_addr_out(write_addr_out), .idx_out(idx_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_asrt++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    data_valid  = 1'b0;
    last_in     = 1'b0;
    load_weight = 1'b0;
    weight_in   = 1'b0;
  endtask

  task automatic send(input logic [8:0] d, input logic l, input logic [11:0] a,
                      input logic [3:0] i);
    data_valid    = 1'b1;
    data_in       = d;
    last_in       = l;
    write_addr_in = a;
    idx_in        = i;
    tick();
  endtask

  task automatic load_kernel(input logic [8:0] k);
    data_valid = 1'b0;
    for (int i = 8; i >= 0; i--) begin
      load_weight = 1'b1;
      weight_in   = k[i];
      tick();
      chk("load_no_out", out_valid, 0);
    end
    idle();
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; data_in = '0; write_addr_in = '0; idx_in = '0;
    idle();
    #2;
    chk("rst_ready", weights_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_addr", write_addr_out, 0);
    chk("rst_idx", idx_out, 0);
    tick();
    reset = 1'b0;
    go = 1'b1;

    // Beat offered before the kernel exists must vanish.
    send(9'h1FF, 1'b1, 12'h0AA, 4'h1);
    idle();
    for (int i = 0; i < 9; i++) begin
      load_weight = 1'b1;
      weight_in   = 1'b1;
      tick();
      chk("early_no_out", out_valid, 0);
      if (i < 8) chk("ready_early", weights_ready, 0);
    end
    idle();
    chk("ready_after_9", weights_ready, 1);
    tick();
    chk("early_beat_lost", out_valid, 0);

    // Single beat group
    send(9'h1FF, 1'b1, 12'h123, 4'h5);
    idle();
    tick();
    chk("single_latency", out_valid, 0);
    tick();
    chk("single_valid", out_valid, 1);
    chk("single_sum", sum_out, 9);
    chk("single_neg", negative_flag, 0);
    chk("single_sat", sat_flag, 0);
    chk("single_addr", write_addr_out, 12'h123);
    chk("single_idx", idx_out, 5);
    tick();
    chk("single_pulse", out_valid, 0);
    chk("single_hold", sum_out, 9);

    // Group of three followed back-to-back by a one-beat group
    send(9'h000, 1'b0, 12'h200, 4'h2);
    send(9'h000, 1'b0, 12'h200, 4'h2);
    send(9'h1FF, 1'b1, 12'h200, 4'h2);
    send(9'h0FF, 1'b1, 12'h201, 4'h3);
    idle();
    tick();
    chk("g3_valid", out_valid, 1);
    chk("g3_sum", sum_out, -9);
    chk("g3_neg", negative_flag, 1);
    chk("g3_sat", sat_flag, 0);
    chk("g3_addr", write_addr_out, 12'h200);
    tick();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_sum", sum_out, 7);
    chk("b2b_neg", negative_flag, 0);
    chk("b2b_idx", idx_out, 3);
    tick();

    // Saturation over 15 beats of +9
    for (int i = 0; i < 15; i++) begin
      send(9'h1FF, (i == 14), 12'h300, 4'h7);
      chk("sat_no_early", out_valid, 0);
    end
    idle();
    tick();
    chk("sat_latency", out_valid, 0);
    tick();
    chk("sat_valid", out_valid, 1);
    chk("sat_sum", sum_out, 127);
    chk("sat_flag", sat_flag, 1);
    send(9'h1FF, 1'b1, 12'h301, 4'h8);
    idle();
    tick();
    tick();
    chk("post_sat_valid", out_valid, 1);
    chk("post_sat_sum", sum_out, 9);
    chk("post_sat_flag", sat_flag, 0);

    // Abort an open group with a reload
    send(9'h1FF, 1'b0, 12'h400, 4'h9);
    send(9'h1FF, 1'b0, 12'h400, 4'h9);
    kern_new = 9'h00F;
    load_kernel(kern_new);
    chk("abort_ready", weights_ready, 1);
    tick();
    chk("abort_no_out", out_valid, 0);
    send(9'h1FF, 1'b1, 12'h401, 4'hA);
    idle();
    tick();
    tick();
    chk("newk_valid", out_valid, 1);
    chk("newk_sum", sum_out, -1);
    chk("newk_neg", negative_flag, 1);
    chk("newk_addr", write_addr_out, 12'h401);

    // Asynchronous reset between edges
    send(9'h1FF, 1'b0, 12'h500, 4'hB);
    send(9'h1FF, 1'b0, 12'h500, 4'hB);
    idle();
    #2 reset = 1'b1;
    #1;
    chk("arst_ready", weights_ready, 0);
    chk("arst_sum", sum_out, 0);
    chk("arst_neg", negative_flag, 0);
    chk("arst_addr", write_addr_out, 0);
    chk("arst_idx", idx_out, 0);
    chk("arst_valid", out_valid, 0);
    #1 reset = 1'b0;
    send(9'h1FF, 1'b1, 12'h501, 4'hC);
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst_no_out", out_valid, 0);
    end
    kern_new = 9'h1FF;
    load_kernel(kern_new);
    send(9'h1FF, 1'b1, 12'h502, 4'hD);
    idle();
    tick();
    tick();
    chk("reload_valid", out_valid, 1);
    chk("reload_sum", sum_out, 9);
    chk("reload_idx", idx_out, 4'hD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
